// File: rtl/incdec_pkg.sv
// Shared types and op-decoding helpers for the incdec_sched counter unit.
package incdec_pkg;

  typedef enum logic [1:0] {
    POST_INC = 2'd0,
    POST_DEC = 2'd1,
    PRE_INC  = 2'd2,
    PRE_DEC  = 2'd3
  } incdec_op_e;

  function automatic logic is_pre(input incdec_op_e op);
    return (op == PRE_INC) || (op == PRE_DEC);
  endfunction

  function automatic logic is_inc(input incdec_op_e op);
    return (op == POST_INC) || (op == PRE_INC);
  endfunction

endpackage

// File: rtl/incdec_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module incdec_rr_arb #(
  parameter int N   = 2,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           enable,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found_s;
  int             idx_s;

  // Rotating priority search starting at the pointer.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    idx_s   = 0;
    ptr_d   = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx_s = int'(ptr_q) + k;
      if (idx_s >= N) begin
        idx_s = idx_s - N;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        gnt_idx = IDW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
    if (enable && found_s) begin
      gnt[gnt_idx] = 1'b1;
      ptr_d = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + IDW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/incdec_sched.sv
// Shared ++/-- unit on one counter, round-robin scheduled across N lanes.
// Define INCDEC_SCHED_SATURATE_EN to make overflowing ops saturate instead of wrap.
module incdec_sched
  import incdec_pkg::*;
#(
  parameter int N   = 2,
  parameter int W   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [2*N-1:0]   req_op,
  input  logic [N-1:0]     req_signed,
  output logic [N-1:0]     gnt,
  input  logic             cfg_load,
  input  logic [W-1:0]     cfg_value,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_ret,
  output logic [W-1:0]     rsp_new,
  output logic             rsp_ovf,
  output logic [W-1:0]     count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [W-1:0] U_MAX = {W{1'b1}};
  localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

  logic [0:0]     state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   ret_q, ret_d;
  logic [W-1:0]   new_q, new_d;
  logic           ovf_q, ovf_d;

  logic           arb_en_s;
  logic           grant_s;
  logic [IDW-1:0] gnt_idx_s;
  incdec_op_e     op_s;
  logic           sgn_s;
  logic [W-1:0]   sum_s;
  logic           ovf_s;
  logic [W-1:0]   res_s;

  // Gating with rst_n keeps gnt low throughout reset.
  assign arb_en_s = rst_n && ((state_q == ST_IDLE) || rsp_ready) && !cfg_load;

  incdec_rr_arb #(.N(N), .IDW(IDW)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .enable  (arb_en_s),
    .gnt     (gnt),
    .gnt_idx (gnt_idx_s)
  );

  assign grant_s = |gnt;
  assign op_s    = incdec_op_e'(req_op[{gnt_idx_s, 1'b0} +: 2]);
  assign sgn_s   = req_signed[gnt_idx_s];

  // Op datapath: wrap sum, boundary detection, optional saturation.
  always_comb begin
    sum_s = is_inc(op_s) ? count_q + W'(1) : count_q - W'(1);
    if (sgn_s) begin
      ovf_s = is_inc(op_s) ? (count_q == S_MAX) : (count_q == S_MIN);
    end else begin
      ovf_s = is_inc(op_s) ? (count_q == U_MAX) : (count_q == '0);
    end
`ifdef INCDEC_SCHED_SATURATE_EN
    // Every saturation limit equals the starting value, so holding old is exact.
    res_s = ovf_s ? count_q : sum_s;
`else
    res_s = sum_s;
`endif
  end

  // Next-state for FSM, counter and response registers.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    id_d    = id_q;
    ret_d   = ret_q;
    new_d   = new_q;
    ovf_d   = ovf_q;
    if (cfg_load) begin
      count_d = cfg_value;
    end else if (grant_s) begin
      count_d = res_s;
    end else begin
      count_d = count_q;
    end
    if (grant_s) begin
      state_d = ST_RESP;
      id_d    = gnt_idx_s;
      ret_d   = is_pre(op_s) ? res_s : count_q;
      new_d   = res_s;
      ovf_d   = ovf_s;
    end else if (rsp_ready) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      id_q    <= '0;
      ret_q   <= '0;
      new_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      id_q    <= id_d;
      ret_q   <= ret_d;
      new_q   <= new_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_ret   = ret_q;
  assign rsp_new   = new_q;
  assign rsp_ovf   = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_incdec_sched.sv
// Scoreboard bench for incdec_sched (N=2, W=4); honours INCDEC_SCHED_SATURATE_EN.
module tb_incdec_sched;
  import incdec_pkg::*;

  localparam int N = 2;
  localparam int W = 4;
  localparam int IDW = 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   ret;
    logic [W-1:0]   nv;
    logic           ovf;
  } rsp_t;

`ifdef INCDEC_SCHED_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [2*N-1:0] req_op;
  logic [N-1:0]   req_signed;
  logic [N-1:0]   gnt;
  logic           cfg_load;
  logic [W-1:0]   cfg_value;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_ret;
  logic [W-1:0]   rsp_new;
  logic           rsp_ovf;
  logic [W-1:0]   count;

  rsp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  incdec_sched #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_signed(req_signed),
    .gnt(gnt), .cfg_load(cfg_load), .cfg_value(cfg_value), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_ret(rsp_ret), .rsp_new(rsp_new),
    .rsp_ovf(rsp_ovf), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [W-1:0] ret, input logic [W-1:0] nv,
                      input logic ovf);
    rsp_t e;
    e.id = IDW'(id); e.ret = ret; e.nv = nv; e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic load(input logic [W-1:0] v);
    cfg_load = 1'b1; cfg_value = v;
    step();
    cfg_load = 1'b0;
    chk("cfg_count", 32'(count), 32'(v));
  endtask

  // Single request from one lane; expects an immediate grant.
  task automatic issue(input int lane, input incdec_op_e op, input logic sgn,
                       input logic [W-1:0] ret, input logic [W-1:0] nv, input logic ovf);
    logic [N-1:0] eg;
    eg = 2'b01 << lane;
    req = eg;
    req_op[2*lane +: 2] = op;
    req_signed[lane] = sgn;
    #1;
    chk("issue_gnt", 32'(gnt), 32'(eg));
    push(lane, ret, nv, ovf);
    step();
    req = '0;
    chk("issue_count", 32'(count), 32'(nv));
  endtask

  // Scoreboard monitor: compares each accepted response.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got response id %0d ret %0h with empty queue", rsp_id, rsp_ret);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_id",  32'(rsp_id),  32'(e.id));
        chk("rsp_ret", 32'(rsp_ret), 32'(e.ret));
        chk("rsp_new", 32'(rsp_new), 32'(e.nv));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
      end
    end
  end

  logic [N-1:0] rr_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [W-1:0] rr_val [4];
  logic         rr_ovf [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rr_val = '{4'h2, 4'h1, 4'h0, (SAT ? 4'h0 : 4'hF)};
    rst_n = 1'b0; req = '0; req_op = '0; req_signed = '0;
    cfg_load = 1'b0; cfg_value = '0; rsp_ready = 1'b1;
    step(); step();
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    rst_n = 1'b1;
    step();

    // Unsigned wrap / saturate
    load(4'hF);
    issue(0, POST_INC, 1'b0, 4'hF, SAT ? 4'hF : 4'h0, 1'b1);

    // Signed boundaries
    load(4'h7);
    issue(1, PRE_INC, 1'b1, SAT ? 4'h7 : 4'h8, SAT ? 4'h7 : 4'h8, 1'b1);
    load(4'h8);
    issue(1, POST_DEC, 1'b1, 4'h8, SAT ? 4'h8 : 4'h7, 1'b1);

    // Round-robin with both lanes held
    load(4'h3);
    req = 2'b11; req_op = {PRE_DEC, PRE_DEC}; req_signed = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gnt", 32'(gnt), 32'(rr_gnt[i]));
      push(i % 2, rr_val[i], rr_val[i], rr_ovf[i]);
      step();
      if (i == 3) begin
        req = '0;
        rsp_ready = 1'b0;
      end
    end
    chk("rr_count", 32'(count), 32'(rr_val[3]));

    // Backpressure: pending (id1) response must hold
    req = 2'b01; req_op[1:0] = POST_INC; req_signed[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_gnt", 32'(gnt), 32'h0);
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_id", 32'(rsp_id), 32'h1);
      chk("bp_ret", 32'(rsp_ret), 32'(rr_val[3]));
      chk("bp_count", 32'(count), 32'(rr_val[3]));
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_gnt", 32'(gnt), 32'h1);
    push(0, rr_val[3], SAT ? 4'h1 : 4'h0, SAT ? 1'b0 : 1'b1);
    step();
    req = '0;
    chk("bp_valid_after", 32'(rsp_valid), 32'h1);
    step();

    // Config priority over a simultaneous request
    cfg_load = 1'b1; cfg_value = 4'h5;
    req = 2'b01; req_op[1:0] = PRE_INC;
    #1;
    chk("cfg_prio_gnt", 32'(gnt), 32'h0);
    step();
    cfg_load = 1'b0;
    chk("cfg_prio_count", 32'(count), 32'h5);
    #1;
    chk("cfg_next_gnt", 32'(gnt), 32'h1);
    push(0, 4'h6, 4'h6, 1'b0);
    step();
    req = '0;
    chk("cfg_next_count", 32'(count), 32'h6);
    step();

    // Reset mid-response: grant lane0 so the pointer moves to 1, then reset
    rsp_ready = 1'b0;
    req = 2'b01; req_op[1:0] = PRE_INC;
    step();
    req = 2'b11;
    chk("mid_valid", 32'(rsp_valid), 32'h1);
    rsp_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    step();
    rst_n = 1'b1;
    req_op = {POST_INC, POST_INC};
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    push(0, 4'h0, 4'h1, 1'b0);
    step();
    req = '0;
    step(); step();
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/incdec_sched.md
Name: incdec_sched

Overview:
- Shared increment/decrement unit with a round-robin scheduler for N requesters.
- Owns one W-bit counter register. Each granted request performs one pre- or post-increment or decrement on it, signed or unsigned.
- Returns the expression value (ret) and the updated variable value (new), matching SV `++`/`--` semantics.
- Sits between per-lane controllers and the shared counter resource; also exposes a configuration load port.

Parameters:
- N, 2, number of requesters (>=2).
- W, 4, counter/data width (>=2).
- IDW, $clog2(N), width of response requester id.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request; held with op/sign stable until granted.
- req_op  input  2*N  per-requester incdec_op_e, slice i = [2i+1:2i].
- req_signed  input  N  1 = signed overflow/saturation rules.
- gnt  output  N  one-hot grant, combinational, only to a requesting lane.
- cfg_load  input  1  load counter.
- cfg_value  input  W  load value.
- rsp_valid  output  1  response pending.
- rsp_ready  input  1  response accepted when valid&ready.
- rsp_id  output  IDW  granted requester index.
- rsp_ret  output  W  expression result (old for post-ops, new for pre-ops).
- rsp_new  output  W  counter value after the op.
- rsp_ovf  output  1  op crossed the range boundary.
- count  output  W  current counter register.

Behaviour:
- Reset (async, rst_n=0): count=0, rsp_valid=0, rsp_id=0, rsp_ret=0, rsp_new=0, rsp_ovf=0, RR pointer=0, FSM=IDLE. gnt=0 while in reset. A pending response is dropped.
- FSM states:
  - IDLE: no response pending.
  - RESP: rsp_valid=1.
- Transitions:
  - IDLE->RESP on grant.
  - RESP->IDLE on rsp_ready with no new grant.
  - RESP->RESP on rsp_ready with a new grant (back-to-back).
  - Otherwise hold.
- Grant eligibility: (IDLE or rsp_ready) and !cfg_load and |req.
- Grant selection: first requesting lane at or after the RR pointer, mod N. After granting lane i, pointer = (i+1) mod N.
- Latency: grant in cycle t -> count, rsp_* registered and rsp_valid=1 in cycle t+1. Throughput is one op per cycle when rsp_ready is held high.
- Op semantics, with old=count:
  - POST_INC: ret=old, new=old+1.
  - POST_DEC: ret=old, new=old-1.
  - PRE_INC: ret=new=old+1.
  - PRE_DEC: ret=new=old-1.
  - Arithmetic is modulo 2^W (wrap).
- Overflow (rsp_ovf):
  - Unsigned: inc from all-ones, dec from 0.
  - Signed: inc from max positive (0111..), dec from min negative (1000..).
  - rsp_ovf is registered with the response.
- Response stability: rsp_* are stable while rsp_valid & !rsp_ready.
- cfg_load: count <= cfg_value next cycle; no grant that cycle. A pending response is unaffected, and rsp_ready is still honoured.
- cfg_load has priority over requests in the same cycle.
- req deasserted before grant: no effect, no state change.

Optional Feature:
- Macro: INCDEC_SCHED_SATURATE_EN.
- When defined, overflowing ops saturate instead of wrapping:
  - Unsigned: inc holds all-ones, dec holds 0.
  - Signed: inc holds max positive, dec holds min negative.
  - rsp_new and count take the saturated value.
  - Pre-ops return the saturated value in ret; post-ops return old.
  - rsp_ovf is still asserted.
- When undefined: wrap arithmetic as above.

Decomposition:
- Package incdec_pkg:
  - typedef enum logic [1:0] incdec_op_e {POST_INC=0, POST_DEC=1, PRE_INC=2, PRE_DEC=3}.
  - Helper functions is_pre(op) and is_inc(op).
- Sub-module incdec_rr_arb:
  - Parameter N.
  - Inputs: req, enable. Outputs: one-hot gnt, granted index.
  - Owns the RR pointer, with the same clk/rst_n.
- Op/overflow/saturation datapath stays in incdec_sched.

Test Plan (W=4, N=2):
1. Reset: assert rst_n=0 mid-response -> rsp_valid=0, count=0, gnt=0 immediately; after release, first grant goes to lane 0.
2. Unsigned wrap: cfg_load 4'hF, then req0 POST_INC unsigned -> rsp_id=0, ret=F, new=0, ovf=1, count=0. With SATURATE_EN: new=F, count=F.
3. Signed: cfg_load 4'h7, req1 PRE_INC signed -> ret=new=8, ovf=1. With SATURATE_EN: ret=new=7. Then cfg_load 4'h8, req1 POST_DEC signed -> ret=8, new=7, ovf=1 (wrap).
4. Round-robin: count=3, both lanes PRE_DEC unsigned held, rsp_ready=1 -> gnt alternates 01,10,01,10. Responses: (id0,ret=2), (id1,ret=1), (id0,ret=0), (id1,ret=F, ovf=1).
5. Backpressure: rsp_ready=0 with pending response and req0 high -> gnt=0, rsp_* and count stable for 5 cycles. Raise rsp_ready -> grant in that same cycle, new response next cycle.
6. Config priority: cfg_load=1, cfg_value=5 with req0 PRE_INC in the same cycle -> gnt=0, count=5. Next cycle grant -> ret=new=6.
